// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg: shared widths, response-buffer depth and the load credit rule.
package dmem_arbiter_pkg;

   localparam int RV32_ADDR_WIDTH     = 32;
   localparam int RV32_DATA_WIDTH     = 32;
   localparam int DMEM_DATA_WIDTH     = 32;
   localparam int DMEM_ARB_FIFO_DEPTH = 2;

   localparam logic [1:0] FIFO_FULL_CNT = 2'(DMEM_ARB_FIFO_DEPTH);
   localparam logic [2:0] FIFO_DEPTH_U  = 3'(DMEM_ARB_FIFO_DEPTH);

   // A load may issue only if its data is guaranteed a FIFO slot when it lands.
   function automatic logic credit_ok(input logic pend, input logic full,
                                      input logic [1:0] cnt, input logic pop);
      logic [2:0] used;
      used = {2'b00, pend} + {1'b0, cnt};
      return (!full && used < FIFO_DEPTH_U) || (used == FIFO_DEPTH_U && pop);
   endfunction

endpackage

// File: rtl/dmem_arbiter_sync_fifo_2.sv
// sync_fifo_2: two-entry synchronous FIFO with flush, used as the load response buffer.
module sync_fifo_2
   import dmem_arbiter_pkg::*;
#(
   parameter int WIDTH = 36
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_flush,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_push_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_pop_data,
   output logic             o_full,
   output logic             o_empty,
   output logic [1:0]       o_count
);

   logic [WIDTH-1:0] r_mem [2];
   logic             r_wptr;
   logic             r_rptr;
   logic [1:0]       r_count;
   logic             w_push;
   logic             w_pop;

   assign o_full     = (r_count == FIFO_FULL_CNT);
   assign o_empty    = (r_count == 2'd0);
   assign o_count    = r_count;
   assign o_pop_data = r_mem[r_rptr];
   assign w_pop      = i_pop & ~o_empty;
   assign w_push     = i_push & (~o_full | w_pop);

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr] <= i_push_data;
   end

   always_ff @(posedge clk) begin
      if (rst || i_flush) begin
         r_wptr  <= 1'b0;
         r_rptr  <= 1'b0;
         r_count <= 2'd0;
      end else begin
         if (w_push) r_wptr <= ~r_wptr;
         if (w_pop) r_rptr <= ~r_rptr;
         r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin load/store arbiter for a single dmem port with
// credit-limited loads and an in-order two-entry load response buffer.
module dmem_arbiter
   import dmem_arbiter_pkg::*;
#(
   parameter int TAG_WIDTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       i_flush,
   input  logic                       i_ld_req_valid,
   output logic                       o_ld_req_ready,
   input  logic [RV32_ADDR_WIDTH-1:0] i_ld_req_addr,
   input  logic [TAG_WIDTH-1:0]       i_ld_req_tag,
   input  logic                       i_st_req_valid,
   output logic                       o_st_req_ready,
   input  logic [RV32_ADDR_WIDTH-1:0] i_st_req_addr,
   input  logic [RV32_DATA_WIDTH-1:0] i_st_req_data,
   output logic                       o_ld_resp_valid,
   input  logic                       i_ld_resp_ready,
   output logic [DMEM_DATA_WIDTH-1:0] o_ld_resp_data,
   output logic [TAG_WIDTH-1:0]       o_ld_resp_tag,
   output logic [RV32_ADDR_WIDTH-1:0] o_dmem_addr,
   output logic                       o_dmem_wr_en,
   output logic [RV32_DATA_WIDTH-1:0] o_dmem_wr_data,
   input  logic [DMEM_DATA_WIDTH-1:0] i_dmem_rd_data
);

   localparam int ENTRY_W = DMEM_DATA_WIDTH + TAG_WIDTH;

   logic               r_rd_pend;
   logic [TAG_WIDTH-1:0] r_rd_tag;
   logic               r_ld_first;
   logic               w_go;
   logic               w_pop;
   logic               w_ld_elig;
   logic               w_ld_cand;
   logic               w_contest;
   logic               w_full;
   logic               w_empty;
   logic [1:0]         w_count;
   logic [ENTRY_W-1:0] w_head;

   assign w_go            = ~rst & ~i_flush;
   assign o_ld_resp_valid = w_go & ~w_empty;
   assign w_pop           = o_ld_resp_valid & i_ld_resp_ready;
   assign w_ld_elig       = credit_ok(r_rd_pend, w_full, w_count, w_pop);
   assign w_ld_cand       = w_go & i_ld_req_valid & w_ld_elig;
   assign w_contest       = w_ld_cand & i_st_req_valid;
   // r_ld_first breaks ties only; an uncontested requester always wins.
   assign o_ld_req_ready  = w_ld_cand & (~i_st_req_valid | r_ld_first);
   assign o_st_req_ready  = w_go & i_st_req_valid & ~o_ld_req_ready;
   assign o_dmem_addr     = o_ld_req_ready ? i_ld_req_addr : i_st_req_addr;
   assign o_dmem_wr_en    = o_st_req_ready;
   assign o_dmem_wr_data  = i_st_req_data;
   assign o_ld_resp_data  = w_head[ENTRY_W-1:TAG_WIDTH];
   assign o_ld_resp_tag   = w_head[TAG_WIDTH-1:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rd_pend  <= 1'b0;
         r_rd_tag   <= '0;
         r_ld_first <= 1'b1;
      end else begin
         r_rd_pend <= o_ld_req_ready;
         r_rd_tag  <= i_ld_req_tag;
         if (w_contest) r_ld_first <= ~o_ld_req_ready;
      end
   end

   sync_fifo_2 #(
      .WIDTH(ENTRY_W)
   ) u_resp_fifo (
      .clk        (clk),
      .rst        (rst),
      .i_flush    (i_flush),
      .i_push     (r_rd_pend),
      .i_push_data({i_dmem_rd_data, r_rd_tag}),
      .i_pop      (w_pop),
      .o_pop_data (w_head),
      .o_full     (w_full),
      .o_empty    (w_empty),
      .o_count    (w_count)
   );

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scenarios plus a randomized run against a queue-based model.
module tb_dmem_arbiter;

   localparam int TW = 4;

   typedef struct {
      logic [31:0]   d;
      logic [TW-1:0] t;
      int            c;
   } exp_s;

   logic          clk = 1'b0;
   logic          rst, flush, mem_init;
   logic          ld_v, st_v, resp_rdy;
   logic [31:0]   ld_a, st_a, st_d, rd_data;
   logic [TW-1:0] ld_t, resp_t;
   logic          ld_rdy, st_rdy, resp_v, dm_we;
   logic [31:0]   resp_d, dm_a, dm_wd;
   int            checks = 0;
   int            failures = 0;
   logic [31:0]   mem [0:255];
   logic [31:0]   sh  [0:255];

   always #5 clk = ~clk;

   dmem_arbiter #(.TAG_WIDTH(TW)) dut (
      .clk            (clk),
      .rst            (rst),
      .i_flush        (flush),
      .i_ld_req_valid (ld_v),
      .o_ld_req_ready (ld_rdy),
      .i_ld_req_addr  (ld_a),
      .i_ld_req_tag   (ld_t),
      .i_st_req_valid (st_v),
      .o_st_req_ready (st_rdy),
      .i_st_req_addr  (st_a),
      .i_st_req_data  (st_d),
      .o_ld_resp_valid(resp_v),
      .i_ld_resp_ready(resp_rdy),
      .o_ld_resp_data (resp_d),
      .o_ld_resp_tag  (resp_t),
      .o_dmem_addr    (dm_a),
      .o_dmem_wr_en   (dm_we),
      .o_dmem_wr_data (dm_wd),
      .i_dmem_rd_data (rd_data)
   );

   function automatic logic [31:0] init_val(input int i);
      return (i == 4) ? 32'hCAFEBABE : 32'h5A000000 ^ (32'(i) * 32'h00010203);
   endfunction

   always @(posedge clk) begin
      if (mem_init) for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
      else if (dm_we) mem[dm_a[9:2]] <= dm_wd;
      rd_data <= mem[dm_a[9:2]];
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle;
      ld_v = 1'b0;
      st_v = 1'b0;
      flush = 1'b0;
   endtask

   task automatic do_reset;
      idle();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1; flush = 1'b0; resp_rdy = 1'b1;
      ld_v = 1'b1; ld_a = 32'h10; ld_t = 4'd1;
      st_v = 1'b1; st_a = 32'h30; st_d = 32'h1;
      #1;
      checks++;
      if ({ld_rdy, st_rdy, dm_we, resp_v} !== 4'b0000) begin
         failures++;
         $display("FAIL reset_outputs got=%b exp=0000", {ld_rdy, st_rdy, dm_we, resp_v});
      end
      tick();
      rst = 1'b0;
      idle();
      #1;
      checks++;
      if (resp_v !== 1'b0) begin
         failures++;
         $display("FAIL reset_resp_empty got=%b exp=0", resp_v);
      end
      tick();
   endtask

   task automatic test_load_only;
      do_reset();
      resp_rdy = 1'b1;
      ld_v = 1'b1; ld_a = 32'h10; ld_t = 4'd3;
      #1;
      checks++;
      if (ld_rdy !== 1'b1 || dm_a !== 32'h10 || dm_we !== 1'b0) begin
         failures++;
         $display("FAIL ld_issue got rdy=%b addr=%h we=%b exp rdy=1 addr=10 we=0", ld_rdy, dm_a, dm_we);
      end
      tick();
      idle();
      #1;
      checks++;
      if (resp_v !== 1'b0) begin
         failures++;
         $display("FAIL ld_latency_n1 got valid=%b exp=0", resp_v);
      end
      tick();
      checks++;
      if (resp_v !== 1'b1 || resp_d !== 32'hCAFEBABE || resp_t !== 4'd3) begin
         failures++;
         $display("FAIL ld_resp got v=%b d=%h t=%0d exp v=1 d=cafebabe t=3", resp_v, resp_d, resp_t);
      end
      tick();
      checks++;
      if (resp_v !== 1'b0) begin
         failures++;
         $display("FAIL ld_resp_popped got valid=%b exp=0", resp_v);
      end
   endtask

   task automatic test_store_load;
      do_reset();
      resp_rdy = 1'b1;
      st_v = 1'b1; st_a = 32'h20; st_d = 32'h12345678;
      #1;
      checks++;
      if (st_rdy !== 1'b1 || dm_we !== 1'b1 || dm_a !== 32'h20 || dm_wd !== 32'h12345678) begin
         failures++;
         $display("FAIL st_issue got rdy=%b we=%b addr=%h wd=%h exp 1 1 20 12345678", st_rdy, dm_we, dm_a, dm_wd);
      end
      tick();
      st_v = 1'b0;
      ld_v = 1'b1; ld_a = 32'h20; ld_t = 4'd1;
      #1;
      checks++;
      if (ld_rdy !== 1'b1) begin
         failures++;
         $display("FAIL st_ld_accept got rdy=%b exp=1", ld_rdy);
      end
      tick();
      idle();
      tick();
      checks++;
      if (resp_v !== 1'b1 || resp_d !== 32'h12345678 || resp_t !== 4'd1) begin
         failures++;
         $display("FAIL st_ld_resp got v=%b d=%h t=%0d exp v=1 d=12345678 t=1", resp_v, resp_d, resp_t);
      end
      tick();
   endtask

   task automatic test_round_robin;
      do_reset();
      resp_rdy = 1'b1;
      ld_v = 1'b1; ld_a = 32'h40; ld_t = 4'd2;
      st_v = 1'b1; st_a = 32'h80;
      for (int k = 0; k < 4; k++) begin
         logic exp_l;
         exp_l = (k % 2 == 0);
         st_d = 32'hDEAD0000 + 32'(k);
         #1;
         checks++;
         if (ld_rdy !== exp_l || st_rdy !== !exp_l || dm_we !== !exp_l) begin
            failures++;
            $display("FAIL rr_grant_%0d got ld=%b st=%b we=%b exp ld=%b", k, ld_rdy, st_rdy, dm_we, exp_l);
         end
         tick();
      end
      idle();
      tick();
      tick();
   endtask

   task automatic test_backpressure;
      int acc;
      int got;
      do_reset();
      resp_rdy = 1'b0;
      acc = 0;
      ld_v = 1'b1;
      for (int k = 0; k < 6; k++) begin
         ld_t = TW'(acc);
         ld_a = 32'h100 + 32'(4 * acc);
         #1;
         if (ld_rdy) acc++;
         tick();
      end
      ld_t = TW'(acc);
      ld_a = 32'h100 + 32'(4 * acc);
      #1;
      checks++;
      if (acc != 2 || ld_rdy !== 1'b0) begin
         failures++;
         $display("FAIL bp_stall got accepted=%0d rdy=%b exp accepted=2 rdy=0", acc, ld_rdy);
      end
      resp_rdy = 1'b1;
      got = 0;
      for (int k = 0; k < 20 && got < 4; k++) begin
         ld_v = (acc < 4);
         ld_t = TW'(acc);
         ld_a = 32'h100 + 32'(4 * acc);
         #1;
         if (resp_v) begin
            checks++;
            if (resp_t !== TW'(got) || resp_d !== init_val(64 + got)) begin
               failures++;
               $display("FAIL bp_order got t=%0d d=%h exp t=%0d d=%h", resp_t, resp_d, got, init_val(64 + got));
            end
            got++;
         end
         if (ld_v && ld_rdy) acc++;
         tick();
      end
      idle();
      checks++;
      if (got != 4 || acc != 4) begin
         failures++;
         $display("FAIL bp_drain got resp=%0d accepted=%0d exp 4 4", got, acc);
      end
   endtask

   task automatic test_flush;
      int seen;
      do_reset();
      resp_rdy = 1'b1;
      ld_v = 1'b1; ld_t = 4'd1; ld_a = 32'h104;
      #1;
      checks++;
      if (ld_rdy !== 1'b1) begin
         failures++;
         $display("FAIL fl_ld1 got rdy=%b exp=1", ld_rdy);
      end
      tick();
      ld_t = 4'd2; ld_a = 32'h108;
      #1;
      checks++;
      if (ld_rdy !== 1'b1) begin
         failures++;
         $display("FAIL fl_ld2 got rdy=%b exp=1", ld_rdy);
      end
      tick();
      flush = 1'b1; ld_t = 4'd5; st_v = 1'b1; st_a = 32'h88; st_d = 32'h0BAD0BAD;
      #1;
      checks++;
      if ({ld_rdy, st_rdy, dm_we} !== 3'b000) begin
         failures++;
         $display("FAIL fl_block got %b exp 000", {ld_rdy, st_rdy, dm_we});
      end
      tick();
      idle();
      seen = 0;
      for (int k = 0; k < 6; k++) begin
         #1;
         if (resp_v) seen++;
         tick();
      end
      checks++;
      if (seen != 0) begin
         failures++;
         $display("FAIL fl_no_resp got %0d responses exp 0", seen);
      end
      ld_v = 1'b1; ld_t = 4'd7; ld_a = 32'h10C;
      #1;
      checks++;
      if (ld_rdy !== 1'b1) begin
         failures++;
         $display("FAIL fl_new_ld got rdy=%b exp=1", ld_rdy);
      end
      tick();
      idle();
      for (int k = 0; k < 6; k++) begin
         #1;
         if (resp_v) begin
            seen++;
            checks++;
            if (resp_t !== 4'd7 || resp_d !== init_val(67)) begin
               failures++;
               $display("FAIL fl_new_resp got t=%0d d=%h exp t=7 d=%h", resp_t, resp_d, init_val(67));
            end
         end
         tick();
      end
      checks++;
      if (seen != 1) begin
         failures++;
         $display("FAIL fl_resp_count got %0d exp 1", seen);
      end
   endtask

   task automatic test_reset_full;
      do_reset();
      resp_rdy = 1'b0;
      ld_v = 1'b1; ld_t = 4'd4; ld_a = 32'h110;
      st_v = 1'b1; st_a = 32'h84; st_d = 32'h77;
      #1;
      checks++;
      if (ld_rdy !== 1'b1 || st_rdy !== 1'b0) begin
         failures++;
         $display("FAIL rf_first got ld=%b st=%b exp ld=1 st=0", ld_rdy, st_rdy);
      end
      tick();
      st_v = 1'b0; ld_t = 4'd5; ld_a = 32'h114;
      #1;
      checks++;
      if (ld_rdy !== 1'b1) begin
         failures++;
         $display("FAIL rf_second got rdy=%b exp=1", ld_rdy);
      end
      tick();
      idle();
      tick();
      ld_v = 1'b1;
      #1;
      checks++;
      if (resp_v !== 1'b1 || ld_rdy !== 1'b0) begin
         failures++;
         $display("FAIL rf_full got v=%b rdy=%b exp v=1 rdy=0", resp_v, ld_rdy);
      end
      rst = 1'b1; st_v = 1'b1;
      #1;
      checks++;
      if ({ld_rdy, st_rdy, dm_we, resp_v} !== 4'b0000) begin
         failures++;
         $display("FAIL rf_rst_cycle got %b exp 0000", {ld_rdy, st_rdy, dm_we, resp_v});
      end
      tick();
      rst = 1'b0; ld_t = 4'd6; ld_a = 32'h118;
      #1;
      checks++;
      if (resp_v !== 1'b0 || ld_rdy !== 1'b1 || st_rdy !== 1'b0) begin
         failures++;
         $display("FAIL rf_after got v=%b ld=%b st=%b exp v=0 ld=1 st=0", resp_v, ld_rdy, st_rdy);
      end
      tick();
      idle();
      resp_rdy = 1'b1;
      tick();
      checks++;
      if (resp_v !== 1'b1 || resp_t !== 4'd6 || resp_d !== init_val(70)) begin
         failures++;
         $display("FAIL rf_new_resp got v=%b t=%0d d=%h exp v=1 t=6 d=%h", resp_v, resp_t, resp_d, init_val(70));
      end
      tick();
   endtask

   task automatic test_random;
      exp_s q[$];
      bit   m_ptr;
      int   now;
      bit   exp_v, pop, elig, l_ok, expl, exps;
      idle();
      rst = 1'b1; mem_init = 1'b1;
      tick();
      rst = 1'b0; mem_init = 1'b0;
      for (int i = 0; i < 256; i++) sh[i] = init_val(i);
      m_ptr = 1'b1;
      now = 0;
      for (int n = 0; n < 600; n++) begin
         ld_v     = ($urandom_range(0, 99) < 60);
         st_v     = ($urandom_range(0, 99) < 40);
         resp_rdy = ($urandom_range(0, 99) < 70);
         flush    = ($urandom_range(0, 99) < 4);
         ld_a     = 32'($urandom_range(0, 63)) << 2;
         st_a     = 32'($urandom_range(0, 63)) << 2;
         ld_t     = TW'($urandom);
         st_d     = $urandom;
         #1;
         exp_v = !flush && q.size() > 0 && (now - q[0].c >= 2);
         checks++;
         if (resp_v !== exp_v) begin
            failures++;
            $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", now, resp_v, exp_v);
         end else if (exp_v && (resp_d !== q[0].d || resp_t !== q[0].t)) begin
            failures++;
            $display("FAIL rnd_payload cyc=%0d got d=%h t=%0d exp d=%h t=%0d", now, resp_d, resp_t, q[0].d, q[0].t);
         end
         pop  = exp_v && resp_rdy;
         elig = q.size() < 2 || (q.size() == 2 && pop);
         l_ok = !flush && ld_v && elig;
         expl = l_ok && (!st_v || m_ptr);
         exps = !flush && st_v && !expl;
         checks++;
         if ({ld_v && ld_rdy, st_v && st_rdy, dm_we} !== {expl, exps, exps} || (ld_rdy && st_rdy)) begin
            failures++;
            $display("FAIL rnd_grant cyc=%0d got ld=%b st=%b we=%b exp ld=%b st=%b", now, ld_rdy, st_rdy, dm_we, expl, exps);
         end
         if (expl || exps) begin
            checks++;
            if (dm_a !== (expl ? ld_a : st_a) || (exps && dm_wd !== st_d)) begin
               failures++;
               $display("FAIL rnd_issue cyc=%0d got a=%h wd=%h exp a=%h", now, dm_a, dm_wd, expl ? ld_a : st_a);
            end
         end
         if (pop) void'(q.pop_front());
         if (flush) q.delete();
         if (expl) q.push_back('{sh[ld_a[9:2]], ld_t, now});
         if (exps) sh[st_a[9:2]] = st_d;
         if (l_ok && st_v) m_ptr = !expl;
         now++;
         tick();
      end
      idle();
   endtask

   initial begin
      rst = 1'b1; mem_init = 1'b1; resp_rdy = 1'b0;
      ld_a = '0; ld_t = '0; st_a = '0; st_d = '0;
      idle();
      tick();
      mem_init = 1'b0;
      test_reset();
      test_load_only();
      test_store_load();
      test_round_robin();
      test_backpressure();
      test_flush();
      test_reset_full();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end

endmodule
